divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 122 ++++++++++++
 tb/tb_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first; done pulses WIDTH+1 cycles after start (1 for B=0).
// No backpressure: start is taken only in IDLE, and results hold until the next operation completes.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] aq_q, aq_d;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   pr_shift;
    logic [WIDTH-1:0] pr_trial;
    logic [WIDTH-1:0] pr_step;
    logic [WIDTH-1:0] aq_step;
    logic             q_bit;

    // aq_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    // The trial subtraction only needs WIDTH bits: whenever it is taken the true difference is below B.
    always_comb begin
        pr_shift = {pr_q, aq_q[WIDTH-1]};
        q_bit    = (pr_shift >= {1'b0, b_q});
        pr_trial = pr_shift[WIDTH-1:0] - b_q;
        pr_step  = q_bit ? pr_trial : pr_shift[WIDTH-1:0];
        aq_step  = {aq_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        aq_d    = aq_q;
        pr_d    = pr_q;
        b_d     = b_q;
        out_d   = out_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    aq_d  = A;
                    b_d   = B;
                    pr_d  = '0;
                    cnt_d = '0;
                    if (B == '0) begin
                        state_d = DONE;
                        out_d   = '1;
                        rem_d   = A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                pr_d  = pr_step;
                aq_d  = aq_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    out_d   = aq_step;
                    rem_d   = pr_step;
                    dbz_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            aq_q    <= '0;
            pr_q    <= '0;
            b_q     <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aq_q    <= aq_d;
            pr_q    <= pr_d;
            b_q     <= b_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign out         = out_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_divider.sv
// Bench for divider: table of known quotients plus random operands, results checked from a scoreboard on each done pulse.
module tb_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] out;
    logic [W-1:0] rem;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .out         (out),
        .rem         (rem),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks outputs hold otherwise.
    logic [W-1:0] out_h = '0;
    logic [W-1:0] rem_h = '0;
    logic         dbz_h = 1'b0;
    logic         done_h = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            done_h = 1'b0;
        end else if (done) begin
            chk("done_single_cycle", done_h, 0);
            chk("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("quotient", out, e.q);
                chk("remainder", rem, e.r);
                chk("div_by_zero", div_by_zero, e.dbz);
            end
        end else begin
            chk("out_stable", out, out_h);
            chk("rem_stable", rem, rem_h);
            chk("dbz_stable", div_by_zero, dbz_h);
        end
        out_h  = out;
        rem_h  = rem;
        dbz_h  = div_by_zero;
        done_h = done;
    end

    // Issue one division and wait for its done pulse; operands are scrambled right after the start edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                         input int glitch_at, input bit start_in_done);
        int   n;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        A     = a;
        B     = b;
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        sb.push_back(e);
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                start = 1'b0;
                A     = $urandom;
                B     = $urandom;
            end
            if (glitch_at != 0 && n == glitch_at) begin
                start = 1'b1;
                A     = 50;
                B     = 5;
            end
            if (glitch_at != 0 && n == glitch_at + 1) start = 1'b0;
            if (done) seen = 1;
        end
        chk("done_latency", n, (b == 0) ? 1 : W + 1);
        if (start_in_done) begin
            start = 1'b1;
            A     = 9;
            B     = 3;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("start_in_done_ignored", busy, 0);
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t         vecs[8];
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 100,          b: 7,            q: 14,           r: 2,            dbz: 1'b0};
        vecs[1] = '{a: 32'hFFFFFFFF, b: 1,            q: 32'hFFFFFFFF, r: 0,            dbz: 1'b0};
        vecs[2] = '{a: 32'hFFFFFFFF, b: 32'h80000000, q: 1,            r: 32'h7FFFFFFF, dbz: 1'b0};
        vecs[3] = '{a: 3,            b: 10,           q: 0,            r: 3,            dbz: 1'b0};
        vecs[4] = '{a: 0,            b: 5,            q: 0,            r: 0,            dbz: 1'b0};
        vecs[5] = '{a: 5,            b: 0,            q: 32'hFFFFFFFF, r: 5,            dbz: 1'b1};
        vecs[6] = '{a: 9,            b: 3,            q: 3,            r: 0,            dbz: 1'b0};
        vecs[7] = '{a: 32'h80000000, b: 32'hFFFFFFFF, q: 0,            r: 32'h80000000, dbz: 1'b0};

        #3;
        chk("reset_out", out, 0);
        chk("reset_rem", rem, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dbz", div_by_zero, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, 0, (i == 3));
            repeat (i % 3) @(posedge clk);
        end

        // A second start mid-run must not disturb the operation in flight.
        do_op(100, 7, 14, 2, 1'b0, 10, 1'b0);

        // Async reset mid-run aborts the operation without a done pulse.
        @(posedge clk);
        #1;
        start = 1'b1;
        A     = 100;
        B     = 7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out", out, 0);
        chk("abort_rem", rem, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dbz", div_by_zero, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_idle_busy", busy, 0);
        do_op(20, 6, 3, 2, 1'b0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
            if (rb == 0) rb = 1;
            do_op(ra, rb, ra / rb, ra % rb, 1'b0, 0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
